// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_23060201_ifu_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [31:0]       MBASE     = 32'h8000_0000;
    localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

    typedef enum logic [STATE_W-1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_NPC  = 2'd3
    } ifu_state_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060201_ifu_if.sv
// Instruction memory read bus: address channel plus read-data channel.
interface ysyx_23060201_ifu_if #(
    parameter int unsigned ADDR_W = 32
) ();
    import ysyx_23060201_ifu_pkg::*;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [INST_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: one outstanding read, result held for the IDU until
// accepted, then waits for the next PC from the EXU.
module ysyx_23060201_ifu
    import ysyx_23060201_ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MBASE)
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_23060201_ifu_if.master imem,
    output logic [INST_W-1:0]   out_inst,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [ADDR_W-1:0]   dnpc,
    input  logic                dnpc_valid,
    output logic [CNT_W-1:0]    fetch_cnt
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_err_q, out_err_d;
    logic              out_valid_q, out_valid_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

    // Next-state and payload logic; handshake strobes follow the next state
    // so they are registered and aligned with the state they belong to.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_err_d   = out_err_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            S_REQ: begin
                if (arvalid_q && imem.arready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rready_q && imem.rvalid) begin
                    state_d    = S_HOLD;
                    out_inst_d = imem.rdata;
                    out_pc_d   = pc_q;
                    out_err_d  = (imem.rresp != RESP_OKAY);
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d     = S_NPC;
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                end
            end
            S_NPC: begin
                if (dnpc_valid) begin
                    pc_d = dnpc;
                    if (is_word_aligned(dnpc[1:0])) begin
                        state_d = S_REQ;
                    end else begin
                        // Misaligned target is reported without touching the bus.
                        state_d    = S_HOLD;
                        out_inst_d = '0;
                        out_pc_d   = dnpc;
                        out_err_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        arvalid_d   = (state_d == S_REQ);
        rready_d    = (state_d == S_WAIT);
        out_valid_d = (state_d == S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem.araddr  = pc_q;
    assign imem.arvalid = arvalid_q;
    assign imem.rready  = rready_q;
    assign out_inst     = out_inst_q;
    assign out_pc       = out_pc_q;
    assign out_err      = out_err_q;
    assign out_valid    = out_valid_q;
    assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Directed plus randomized bench for the fetch unit against a transaction-level model.
module tb_ysyx_23060201_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dnpc;
    logic        dnpc_valid;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: PC the IFU should be fetching, expected held result, handshake count.
    logic [31:0] model_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_err;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    ysyx_23060201_ifu_if #(.ADDR_W(32)) imem_if ();

    ysyx_23060201_ifu #(.ADDR_W(32), .RESET_PC(32'h8000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (imem_if),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dnpc       (dnpc),
        .dnpc_valid (dnpc_valid),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk1("ar_r_exclusive", imem_if.arvalid & imem_if.rready, 1'b0);
    endtask

    task automatic check_hold(input string tag);
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk32({tag, "_inst"}, out_inst, exp_inst);
        chk32({tag, "_pc"}, out_pc, exp_pc);
        chk1({tag, "_err"}, out_err, exp_err);
        chk32({tag, "_cnt"}, fetch_cnt, exp_cnt);
    endtask

    // Acts as the memory for one fetch of model_pc.
    task automatic serve(input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        while (imem_if.arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk1("arvalid_seen", imem_if.arvalid, 1'b1);
        chk32("araddr", imem_if.araddr, model_pc);
        for (int i = 0; i < ar_wait; i++) begin
            imem_if.arready = 1'b0;
            imem_if.rvalid  = 1'($urandom_range(0, 1));
            dnpc            = $urandom;
            dnpc_valid      = 1'($urandom_range(0, 1));
            tick();
            chk1("arvalid_hold", imem_if.arvalid, 1'b1);
            chk32("araddr_hold", imem_if.araddr, model_pc);
            chk1("rready_in_req", imem_if.rready, 1'b0);
        end
        imem_if.rvalid  = 1'b0;
        dnpc_valid      = 1'b0;
        imem_if.arready = 1'b1;
        tick();
        imem_if.arready = 1'b0;
        chk1("rready_wait", imem_if.rready, 1'b1);
        chk1("arvalid_drop", imem_if.arvalid, 1'b0);
        for (int i = 0; i < r_wait; i++) begin
            dnpc_valid = 1'($urandom_range(0, 1));
            tick();
            chk1("rready_hold", imem_if.rready, 1'b1);
            chk1("no_early_valid", out_valid, 1'b0);
        end
        dnpc_valid      = 1'b0;
        imem_if.rvalid  = 1'b1;
        imem_if.rdata   = data;
        imem_if.rresp   = resp;
        tick();
        imem_if.rvalid  = 1'b0;
        imem_if.rdata   = $urandom;
        imem_if.rresp   = 2'($urandom_range(0, 3));
        exp_inst = data;
        exp_pc   = model_pc;
        exp_err  = (resp != 2'b00);
        check_hold("fetch");
        chk1("rready_after", imem_if.rready, 1'b0);
    endtask

    // Holds out_ready low for w cycles (with stray dnpc), then completes the handshake.
    task automatic hold_ack(input int w);
        for (int i = 0; i < w; i++) begin
            out_ready  = 1'b0;
            dnpc       = $urandom;
            dnpc_valid = 1'($urandom_range(0, 1));
            tick();
            check_hold("hold_stable");
        end
        dnpc_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready  = 1'b0;
        exp_cnt    = exp_cnt + 32'd1;
        chk1("npc_valid_low", out_valid, 1'b0);
        chk32("fetch_cnt", fetch_cnt, exp_cnt);
        chk1("npc_no_request", imem_if.arvalid, 1'b0);
    endtask

    task automatic give_dnpc(input logic [31:0] a);
        dnpc       = a;
        dnpc_valid = 1'b1;
        tick();
        dnpc_valid = 1'b0;
        model_pc   = a;
        if (a[1:0] == 2'b00) begin
            chk1("dnpc_arvalid", imem_if.arvalid, 1'b1);
            chk32("dnpc_araddr", imem_if.araddr, a);
            chk1("dnpc_no_valid", out_valid, 1'b0);
        end else begin
            chk1("misalign_no_ar", imem_if.arvalid, 1'b0);
            exp_inst = 32'h0;
            exp_pc   = a;
            exp_err  = 1'b1;
            check_hold("misalign");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        out_ready       = 1'b0;
        dnpc            = 32'h0;
        dnpc_valid      = 1'b0;
        imem_if.arready = 1'b0;
        imem_if.rvalid  = 1'b0;
        imem_if.rdata   = 32'h0;
        imem_if.rresp   = 2'b00;
        exp_cnt         = 32'h0;
        model_pc        = 32'h8000_0000;

        // Reset values
        repeat (3) @(negedge clk);
        chk1("rst_arvalid", imem_if.arvalid, 1'b0);
        chk1("rst_rready", imem_if.rready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_err", out_err, 1'b0);
        chk32("rst_out_inst", out_inst, 32'h0);
        chk32("rst_out_pc", out_pc, 32'h0);
        chk32("rst_fetch_cnt", fetch_cnt, 32'h0);
        chk32("rst_araddr", imem_if.araddr, 32'h8000_0000);

        // Reset release: arvalid cycle 1, result cycle 3
        rst = 1'b1;
        tick();
        chk1("cycle1_arvalid", imem_if.arvalid, 1'b1);
        serve(0, 0, 32'h0000_0413, 2'b00);
        hold_ack(4);

        // arready low for 5 cycles
        give_dnpc(32'h8000_0004);
        serve(5, 0, 32'h1234_5678, 2'b00);
        hold_ack(0);

        // Misaligned target
        give_dnpc(32'h8000_0006);
        hold_ack(1);

        // Bus fault
        give_dnpc(32'h8000_0008);
        serve(1, 2, 32'hDEAD_BEEF, 2'b10);
        hold_ack(0);

        // Counter wrap from a preloaded all-ones value
        force dut.fetch_cnt_d = 32'hFFFF_FFFF;
        tick();
        release dut.fetch_cnt_d;
        chk32("preload_cnt", fetch_cnt, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        give_dnpc(32'h8000_000C);
        serve(0, 0, $urandom, 2'b00);
        hold_ack(0);

        // Reset during WAIT followed by a stale rvalid
        give_dnpc(32'h8000_0010);
        imem_if.arready = 1'b1;
        tick();
        imem_if.arready = 1'b0;
        chk1("pre_rst_wait", imem_if.rready, 1'b1);
        rst = 1'b0;
        #1;
        chk1("async_rst_rready", imem_if.rready, 1'b0);
        chk1("async_rst_arvalid", imem_if.arvalid, 1'b0);
        chk32("async_rst_cnt", fetch_cnt, 32'h0);
        tick();
        rst             = 1'b1;
        imem_if.rvalid  = 1'b1;
        imem_if.rdata   = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("stale_arvalid", imem_if.arvalid, 1'b1);
            chk32("stale_araddr", imem_if.araddr, 32'h8000_0000);
            chk1("stale_out_valid", out_valid, 1'b0);
        end
        imem_if.rvalid = 1'b0;
        model_pc       = 32'h8000_0000;
        exp_cnt        = 32'h0;
        serve(0, 0, 32'h0000_0013, 2'b00);
        hold_ack(0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            give_dnpc(a);
            if (a[1:0] == 2'b00) begin
                serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
            hold_ack(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
